// File: rtl/fp_share_arbiter.sv
// fp_share_arbiter: two-requester scheduler for the single shared fp add/sub unit.
// Round-robin arbitration with an optional exclusive lock per requester. The
// unit's operands and mode are registered here, and a {valid, id} tag pipeline
// that matches the unit latency routes each result back to the requester that
// issued it.
//
// Ports:
//   i_clock            system clock, rising edge
//   i_reset            synchronous, active-low reset
//   i_rX_req           requester X wants one operation this cycle
//   i_rX_lock          requester X asks for exclusive ownership
//   i_rX_in1/in2/mode  requester X operands and mode (0 add, 1 subtract)
//   o_rX_gnt           requester X operation accepted this cycle
//   o_rX_rvalid        o_rX_result is valid this cycle
//   o_rX_result        result for requester X, zero when not valid
//   o_fp_in1/in2/mode  registered operands and mode driven to the fp unit
//   i_fp_out           fp unit result
//   o_busy             an operation is in flight, or a lock is held
module fp_share_arbiter #(
    parameter int unsigned FP_LAT = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_r0_req,
    input  logic        i_r0_lock,
    input  logic [47:0] i_r0_in1,
    input  logic [47:0] i_r0_in2,
    input  logic        i_r0_mode,
    output logic        o_r0_gnt,
    output logic        o_r0_rvalid,
    output logic [47:0] o_r0_result,
    input  logic        i_r1_req,
    input  logic        i_r1_lock,
    input  logic [47:0] i_r1_in1,
    input  logic [47:0] i_r1_in2,
    input  logic        i_r1_mode,
    output logic        o_r1_gnt,
    output logic        o_r1_rvalid,
    output logic [47:0] o_r1_result,
    output logic [47:0] o_fp_in1,
    output logic [47:0] o_fp_in2,
    output logic        o_fp_mode,
    input  logic [47:0] i_fp_out,
    output logic        o_busy
);

    localparam int unsigned DW = 48;
    localparam int unsigned TW = FP_LAT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_win;
    logic [DW-1:0]   r_fp_in1;
    logic [DW-1:0]   r_fp_in2;
    logic            r_fp_mode;
    logic [TW-1:0]   r_tag_vld;
    logic [TW-1:0]   r_tag_id;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_gnt_any;
    logic            w_out_vld;
    logic            w_out_id;

    // Grant decision and next lock state. A held lock short-circuits the
    // round-robin; a dropped lock falls through and is arbitrated as IDLE in
    // the same cycle.
    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_next_state = ST_IDLE;
        if (!i_reset) begin
            w_gnt0       = 1'b0;
            w_gnt1       = 1'b0;
        end else if (r_state == ST_LOCK0 && i_r0_lock) begin
            w_gnt0       = i_r0_req;
            w_next_state = ST_LOCK0;
        end else if (r_state == ST_LOCK1 && i_r1_lock) begin
            w_gnt1       = i_r1_req;
            w_next_state = ST_LOCK1;
        end else begin
            if (i_r0_req && i_r1_req) begin
                // last_win == 1 means r1 won last, so r0 takes this tie
                w_gnt0 = r_last_win;
                w_gnt1 = ~r_last_win;
            end else begin
                w_gnt0 = i_r0_req;
                w_gnt1 = i_r1_req;
            end
            if (w_gnt0 && i_r0_lock) begin
                w_next_state = ST_LOCK0;
            end else if (w_gnt1 && i_r1_lock) begin
                w_next_state = ST_LOCK1;
            end
        end
    end

    assign w_gnt_any = w_gnt0 | w_gnt1;

    // State, round-robin pointer, operand registers and tag pipeline.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_last_win <= 1'b1;
            r_fp_in1   <= '0;
            r_fp_in2   <= '0;
            r_fp_mode  <= 1'b0;
            r_tag_vld  <= '0;
            r_tag_id   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_gnt_any) begin
                r_last_win <= w_gnt1;
                r_fp_in1   <= w_gnt1 ? i_r1_in1  : i_r0_in1;
                r_fp_in2   <= w_gnt1 ? i_r1_in2  : i_r0_in2;
                r_fp_mode  <= w_gnt1 ? i_r1_mode : i_r0_mode;
            end
            // Shift toward the MSB; the MSB is the output stage.
            r_tag_vld <= TW'({r_tag_vld, w_gnt_any});
            r_tag_id  <= TW'({r_tag_id, w_gnt1});
        end
    end

    assign w_out_vld = r_tag_vld[TW-1];
    assign w_out_id  = r_tag_id[TW-1];

    assign o_r0_gnt    = w_gnt0;
    assign o_r1_gnt    = w_gnt1;
    assign o_r0_rvalid = w_out_vld & ~w_out_id;
    assign o_r1_rvalid = w_out_vld &  w_out_id;
    assign o_r0_result = o_r0_rvalid ? i_fp_out : '0;
    assign o_r1_result = o_r1_rvalid ? i_fp_out : '0;

    assign o_fp_in1  = r_fp_in1;
    assign o_fp_in2  = r_fp_in2;
    assign o_fp_mode = r_fp_mode;
    assign o_busy    = (|r_tag_vld) | (r_state != ST_IDLE);

endmodule

// File: tb/tb_fp_share_arbiter.sv
// Directed bench for fp_share_arbiter. Two instances share one stimulus set:
// u_a with FP_LAT=0 and u_b with FP_LAT=2, each backed by a behavioural fp
// stand-in (integer add/sub) of matching latency.
module tb_fp_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_lock, r0_mode;
    logic        r1_req, r1_lock, r1_mode;
    logic [47:0] r0_in1, r0_in2, r1_in1, r1_in2;

    logic        a_r0_gnt, a_r0_rvalid, a_r1_gnt, a_r1_rvalid, a_fp_mode, a_busy;
    logic [47:0] a_r0_result, a_r1_result, a_fp_in1, a_fp_in2, a_fp_out;
    logic        b_r0_gnt, b_r0_rvalid, b_r1_gnt, b_r1_rvalid, b_fp_mode, b_busy;
    logic [47:0] b_r0_result, b_r1_result, b_fp_in1, b_fp_in2, b_fp_out;
    logic [47:0] b_p0, b_p1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [47:0] fp_model(input logic [47:0] x, input logic [47:0] y,
                                             input logic m);
        return m ? (x - y) : (x + y);
    endfunction

    assign a_fp_out = fp_model(a_fp_in1, a_fp_in2, a_fp_mode);
    always @(posedge clk) begin
        b_p0 <= fp_model(b_fp_in1, b_fp_in2, b_fp_mode);
        b_p1 <= b_p0;
    end
    assign b_fp_out = b_p1;

    fp_share_arbiter #(.FP_LAT(0)) u_a (
        .i_clock(clk), .i_reset(reset),
        .i_r0_req(r0_req), .i_r0_lock(r0_lock), .i_r0_in1(r0_in1), .i_r0_in2(r0_in2),
        .i_r0_mode(r0_mode), .o_r0_gnt(a_r0_gnt), .o_r0_rvalid(a_r0_rvalid),
        .o_r0_result(a_r0_result),
        .i_r1_req(r1_req), .i_r1_lock(r1_lock), .i_r1_in1(r1_in1), .i_r1_in2(r1_in2),
        .i_r1_mode(r1_mode), .o_r1_gnt(a_r1_gnt), .o_r1_rvalid(a_r1_rvalid),
        .o_r1_result(a_r1_result),
        .o_fp_in1(a_fp_in1), .o_fp_in2(a_fp_in2), .o_fp_mode(a_fp_mode),
        .i_fp_out(a_fp_out), .o_busy(a_busy)
    );

    fp_share_arbiter #(.FP_LAT(2)) u_b (
        .i_clock(clk), .i_reset(reset),
        .i_r0_req(r0_req), .i_r0_lock(r0_lock), .i_r0_in1(r0_in1), .i_r0_in2(r0_in2),
        .i_r0_mode(r0_mode), .o_r0_gnt(b_r0_gnt), .o_r0_rvalid(b_r0_rvalid),
        .o_r0_result(b_r0_result),
        .i_r1_req(r1_req), .i_r1_lock(r1_lock), .i_r1_in1(r1_in1), .i_r1_in2(r1_in2),
        .i_r1_mode(r1_mode), .o_r1_gnt(b_r1_gnt), .o_r1_rvalid(b_r1_rvalid),
        .o_r1_result(b_r1_result),
        .o_fp_in1(b_fp_in1), .o_fp_in2(b_fp_in2), .o_fp_mode(b_fp_mode),
        .i_fp_out(b_fp_out), .o_busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_req = 0; r0_lock = 0; r0_mode = 0; r0_in1 = '0; r0_in2 = '0;
        r1_req = 0; r1_lock = 0; r1_mode = 0; r1_in1 = '0; r1_in2 = '0;
    endtask

    // Reset with both requests high: grants must stay low while reset is low.
    // Returns just after the first edge with reset released (cycle 0 begins).
    task automatic do_reset();
        tick();
        clear_inputs();
        reset = 0; r0_req = 1; r1_req = 1;
        tick();
        @(negedge clk);
        chk("rst_a_gnt0", 64'(a_r0_gnt), 64'd0);
        chk("rst_a_gnt1", 64'(a_r1_gnt), 64'd0);
        chk("rst_b_gnt0", 64'(b_r0_gnt), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);
        chk("rst_a_fpin1", 64'(a_fp_in1), 64'd0);
        chk("rst_a_rvalid", 64'({a_r0_rvalid, a_r1_rvalid}), 64'd0);
        tick();
        reset = 1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 0;

        // ---- FP_LAT=0, single r0 op in cycle 5 ----
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t1_idle_busy", 64'(a_busy), 64'd0);
            tick();
        end
        r0_req = 1; r0_in1 = 48'h000100_000000; r0_in2 = 48'h000200_000000; r0_mode = 0;
        @(negedge clk);
        chk("t1_gnt0", 64'(a_r0_gnt), 64'd1);
        chk("t1_gnt1", 64'(a_r1_gnt), 64'd0);
        tick();
        r0_req = 0;
        @(negedge clk);
        chk("t1_fpin1", 64'(a_fp_in1), 64'h000100_000000);
        chk("t1_fpin2", 64'(a_fp_in2), 64'h000200_000000);
        chk("t1_fpmode", 64'(a_fp_mode), 64'd0);
        chk("t1_rvalid0", 64'(a_r0_rvalid), 64'd1);
        chk("t1_result0", 64'(a_r0_result), 64'h000300_000000);
        chk("t1_rvalid1", 64'(a_r1_rvalid), 64'd0);

        // ---- Round-robin tie, 6 cycles from reset ----
        do_reset();
        r0_in1 = 48'h10; r0_in2 = 48'h3; r0_mode = 0;
        r1_in1 = 48'h50; r1_in2 = 48'h8; r1_mode = 1;
        for (int k = 0; k <= 6; k++) begin
            r0_req = (k < 6); r1_req = (k < 6);
            @(negedge clk);
            if (k < 6) begin
                chk("t2_gnt0", 64'(a_r0_gnt), 64'((k % 2) == 0));
                chk("t2_gnt1", 64'(a_r1_gnt), 64'((k % 2) == 1));
            end
            if (k >= 1) begin
                chk("t2_rvalid0", 64'(a_r0_rvalid), 64'(((k - 1) % 2) == 0));
                chk("t2_rvalid1", 64'(a_r1_rvalid), 64'(((k - 1) % 2) == 1));
                chk("t2_result0", 64'(a_r0_result), ((k - 1) % 2 == 0) ? 64'h13 : 64'h0);
                chk("t2_result1", 64'(a_r1_result), ((k - 1) % 2 == 1) ? 64'h48 : 64'h0);
            end
            tick();
        end

        // ---- Lock held by r1 for 4 cycles, then released ----
        do_reset();
        r0_req = 1; r0_in1 = 48'h1; r0_in2 = 48'h1;
        @(negedge clk);
        chk("t3_pre_gnt0", 64'(a_r0_gnt), 64'd1);
        tick();
        r1_req = 1; r1_lock = 1; r1_in1 = 48'h7; r1_in2 = 48'h2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_lock_gnt1", 64'(a_r1_gnt), 64'd1);
            chk("t3_lock_gnt0", 64'(a_r0_gnt), 64'd0);
            tick();
        end
        r1_lock = 0;
        @(negedge clk);
        chk("t3_rel_gnt0", 64'(a_r0_gnt), 64'd1);
        chk("t3_rel_gnt1", 64'(a_r1_gnt), 64'd0);
        tick();

        // ---- FP_LAT=2, 8 back-to-back r0 ops ----
        do_reset();
        for (int c = 0; c < 12; c++) begin
            r0_req  = (c < 8);
            r0_in1  = 48'(32'h1000 + c);
            r0_in2  = 48'(c);
            r0_mode = c[0];
            @(negedge clk);
            if (c < 8) chk("t4_gnt0", 64'(b_r0_gnt), 64'd1);
            chk("t4_rvalid0", 64'(b_r0_rvalid), 64'(c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) begin
                // op k = c-3: even k adds (0x1000+2k), odd k subtracts (0x1000)
                chk("t4_result0", 64'(b_r0_result),
                    ((c - 3) % 2 == 0) ? 64'(32'h1000 + 2 * (c - 3)) : 64'h1000);
            end
            chk("t4_rvalid1", 64'(b_r1_rvalid), 64'd0);
            chk("t4_busy", 64'(b_busy), 64'(c >= 1 && c <= 10));
            tick();
        end

        // ---- FP_LAT=2, reset with two ops in flight ----
        do_reset();
        r0_req = 1; r0_in1 = 48'hAAAA; r0_in2 = 48'h1111;
        @(negedge clk);
        chk("t5_gnt0", 64'(b_r0_gnt), 64'd1);
        tick();
        r0_req = 0; r1_req = 1; r1_in1 = 48'hBBBB; r1_in2 = 48'h2222; r1_mode = 1;
        @(negedge clk);
        chk("t5_gnt1", 64'(b_r1_gnt), 64'd1);
        tick();
        r1_req = 0; reset = 0;
        @(negedge clk);
        chk("t5_busy_pre", 64'(b_busy), 64'd1);
        chk("t5_fpin1_pre", 64'(b_fp_in1), 64'hBBBB);
        tick();
        reset = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_rvalid", 64'({b_r0_rvalid, b_r1_rvalid}), 64'd0);
            chk("t5_busy", 64'(b_busy), 64'd0);
            chk("t5_fpin", 64'({b_fp_in1, b_fp_in2}), 64'd0);
            tick();
        end
        r0_req = 1; r1_req = 1;
        @(negedge clk);
        chk("t5_tie_gnt0", 64'(b_r0_gnt), 64'd1);
        chk("t5_tie_gnt1", 64'(b_r1_gnt), 64'd0);
        tick();

        // ---- Lock gap: r0 owns the unit with req low ----
        do_reset();
        r0_req = 1; r0_lock = 1; r1_req = 1;
        @(negedge clk);
        chk("t6_gnt0", 64'(a_r0_gnt), 64'd1);
        tick();
        r0_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_gap_gnt1", 64'(a_r1_gnt), 64'd0);
            chk("t6_gap_gnt0", 64'(a_r0_gnt), 64'd0);
            chk("t6_gap_busy", 64'(a_busy), 64'd1);
            tick();
        end
        r0_lock = 0;
        @(negedge clk);
        chk("t6_rel_gnt1", 64'(a_r1_gnt), 64'd1);
        tick();
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_share_arbiter.md
# fp_share_arbiter

Two-requester scheduler for the single shared fp_DW add/subtract unit. It sits between the update-Y computation and the Jacobi V-update engine. Each requester sees a grant and a result-valid handshake. The arbiter drives the fp unit operand and mode ports, and routes each result back to its issuer using a tag pipeline that matches the unit's latency. A lock lets one requester keep the unit across a multi-operation sequence, such as a complex multiply-accumulate.

## Interface
- FP_LAT, 0, pipeline stages inside fp_DW from sampling fp_in* to a valid fp_out; legal range 0..4
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-low
- r0_req  in  1  requester 0 (update-Y) wants one operation this cycle
- r0_lock  in  1  requester 0 requests exclusive ownership
- r0_in1, r0_in2  in  48  operands for requester 0
- r0_mode  in  1  0 = add, 1 = subtract
- r0_gnt  out  1  operation of requester 0 accepted this cycle
- r0_rvalid  out  1  r0_result is valid this cycle
- r0_result  out  48  result for requester 0
- r1_req, r1_lock, r1_in1, r1_in2, r1_mode, r1_gnt, r1_rvalid, r1_result: same as r0, for requester 1 (V-update)
- fp_in1, fp_in2  out  48  registered operands to fp_DW
- fp_mode  out  1  registered mode to fp_DW
- fp_out  in  48  fp_DW result
- busy  out  1  an operation is in flight, or lock state is not IDLE

## Operation
- States: IDLE, LOCK0, LOCK1. Register last_win (1 bit).
- Grant decision is combinational from the current state, the req/lock inputs and last_win. At most one gnt per cycle.
- IDLE:
  - Exactly one req → that requester is granted.
  - Both req → the requester that is not last_win is granted (round-robin).
- Any grant to requester x updates last_win to x.
- A grant to x in IDLE with rx_lock=1 → LOCKx next cycle.
- LOCKx with rx_lock=1:
  - Only x can be granted, and it is granted whenever rx_req=1.
  - The other requester's req is ignored; its gnt stays 0.
  - Gaps with rx_req=0 keep ownership.
- LOCKx with rx_lock=0: the state returns to IDLE and that cycle is arbitrated as IDLE.
  - If both requesters assert req that cycle, the other requester wins, because last_win=x.
- rx_lock asserted without rx_req has no effect in IDLE.
- On grant: the winner's in1, in2 and mode are registered into fp_in1, fp_in2 and fp_mode.
- No grant: fp_in*/fp_mode hold their values.
- Tag pipeline has FP_LAT+1 stages of {valid, id}, shifted every cycle. Stage 0 is loaded with {gnt_any, winner}.
  - Output-stage valid with id = x → rx_rvalid=1.
  - rx_result = fp_out when rx_rvalid=1, else 0.
- busy = OR of all tag valids, OR (state != IDLE).
- Requesters must hold req and operands stable until gnt.

## Timing
- Reset (reset=0 at an edge) gives:
  - state IDLE; last_win=1, so r0 wins the first tie.
  - fp_in1 = fp_in2 = 0, fp_mode = 0.
  - All tags invalid.
  - All gnt, rvalid and result outputs 0 (gnt is 0 while reset=0); busy 0.
- Latency: grant in cycle T → fp sees the operands in T+1 → rvalid and result in cycle T+1+FP_LAT.
- Throughput: one operation per cycle, sustained, with no bubbles. Results return in grant order.
- Simultaneous grant and return in the same cycle are independent. One requester can be granted while the other receives rvalid.
- Reset mid-operation: in-flight tags are cleared. No rvalid appears after reset for operations granted before it. A held lock is released.
- Lock starvation is the requester's responsibility. There is no timeout.

## Test plan
- FP_LAT=0, r0 only: r0_req with in1=48'h000100_000000, in2=48'h000200_000000, mode=0 in cycle 5.
  - r0_gnt in cycle 5.
  - fp_in1/fp_in2 carry those values in cycle 6.
  - r0_rvalid in cycle 6 with r0_result = bench model output; r1_rvalid stays 0.
- Both requesters assert req continuously for 6 cycles from reset.
  - Grants alternate r0, r1, r0, r1, r0, r1.
  - rvalid order is identical, one cycle later each.
- Lock: r1 holds req and lock for 4 cycles while r0_req=1.
  - r1 granted 4 times; r0_gnt=0 throughout.
  - r1 drops lock in cycle 5 → r0 granted in cycle 5.
- FP_LAT=2, back-to-back: 8 consecutive r0 ops with distinct operands.
  - 8 consecutive r0_rvalid pulses, starting 3 cycles after the first grant.
  - Results in order; busy falls 1 cycle after the last rvalid.
- Reset mid-flight, FP_LAT=2: grant r0 and r1 on consecutive cycles, then reset=0 for 1 cycle on the next edge.
  - No rvalid afterward; fp_in*=0; busy=0.
  - The next tie goes to r0.
- Lock gap: r0 holds lock with req low for 3 cycles while r1_req=1.
  - r1_gnt stays 0 and state stays LOCK0.
  - busy=1 throughout.
